uart_tx_arbiter: RTL

//  Shares one UART transmitter (TX FSM + serializer + parity + mux) between NUM_REQ requesters.

---
 rtl/uart_tx_arbiter_if.sv | 52 +++++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Purpose : bundles the requester-side and UART-TX-side signals of the
//           uart_tx_arbiter into one interface.
// Modports:
//   master - the arbiter's view: consumes requests/config/TX_BUSY, drives
//            REQ_ACK, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP,
//            GRANT_ID and TX_ERR.
//   slave  - the environment's view (requesters plus UART TX), the mirror.
// Signals:
//   REQ_VALID  [NUM_REQ]            per-requester frame pending
//   REQ_DATA   [NUM_REQ*DATA_WIDTH] requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_ACK    [NUM_REQ]            one-cycle capture pulse
//   CFG_PAR_EN, CFG_PAR_TYP         parity config, sampled at capture
//   TX_BUSY                         busy from the UART TX
//   TX_P_DATA  [DATA_WIDTH]         byte to the UART TX
//   TX_DATA_VALID                   one-cycle frame-start strobe
//   TX_PAR_EN, TX_PAR_TYP           parity config held for the frame
//   GRANT_ID   [clog2(NUM_REQ)]     owner of the current frame
//   TX_ERR                          one-cycle busy-rise timeout pulse
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_ACK;
    logic                          CFG_PAR_EN;
    logic                          CFG_PAR_TYP;
    logic                          TX_BUSY;
    logic [DATA_WIDTH-1:0]         TX_P_DATA;
    logic                          TX_DATA_VALID;
    logic                          TX_PAR_EN;
    logic                          TX_PAR_TYP;
    logic [ID_W-1:0]               GRANT_ID;
    logic                          TX_ERR;

    modport master (
        input  REQ_VALID, REQ_DATA, CFG_PAR_EN, CFG_PAR_TYP, TX_BUSY,
        output REQ_ACK, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP,
               GRANT_ID, TX_ERR
    );

    modport slave (
        output REQ_VALID, REQ_DATA, CFG_PAR_EN, CFG_PAR_TYP, TX_BUSY,
        input  REQ_ACK, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP,
               GRANT_ID, TX_ERR
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Purpose : shares one UART transmitter between NUM_REQ requesters. A
//           round-robin pick captures one requester's byte and parity config,
//           issues a single frame-start strobe, then waits for TX_BUSY to rise
//           and fall before the next grant. If busy never rises within
//           BUSY_TO cycles the frame is dropped and TX_ERR pulses.
// Ports   : CLK, RST (synchronous, active-high), bus (uart_tx_arbiter_if.master)
// Params  : NUM_REQ (>=2), DATA_WIDTH, BUSY_TO
// Option  : define UART_TX_ARB_PRIO_EN to give requester 0 strict priority;
//           requesters 1..NUM_REQ-1 then rotate among themselves and a
//           requester-0 grant leaves the round-robin pointer untouched.
//           Undefined (default): plain round-robin over all requesters.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BUSY_TO    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(BUSY_TO + 1);
`ifdef UART_TX_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [ID_W-1:0]       ptr_q,     ptr_d;
    logic [ID_W-1:0]       gid_q,     gid_d;
    logic [TMR_W-1:0]      timer_q,   timer_d;
    logic [NUM_REQ-1:0]    ack_q,     ack_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  strobe_q,  strobe_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_err;

    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic                  win_upd_ptr;
    logic [ID_W:0]         cand_sum;
    logic [ID_W-1:0]       cand;

    // Winner search: first valid index at ptr+1, ptr+2, ... modulo NUM_REQ.
    // ptr+k never exceeds 2*NUM_REQ-1, so a single conditional subtract
    // replaces the modulo. With priority enabled, index 0 is removed from
    // the rotation and overrides it whenever it is valid.
    always_comb begin
        win_found   = 1'b0;
        win_idx     = '0;
        win_upd_ptr = 1'b1;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!win_found && bus.REQ_VALID[cand] && !(PRIO_EN && cand == '0)) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (PRIO_EN && bus.REQ_VALID[0]) begin
            win_found   = 1'b1;
            win_idx     = '0;
            win_upd_ptr = 1'b0;
        end
    end

    // Next-state and output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        timer_d   = timer_q;
        ack_d     = '0;
        strobe_d  = 1'b0;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_err    = 1'b0;

        case (state_q)
            IDLE: begin
                // A TX still busy from an abandoned frame blocks new grants.
                if (!bus.TX_BUSY && win_found) begin
                    ack_d     = NUM_REQ'(1) << win_idx;
                    strobe_d  = 1'b1;
                    data_d    = bus.REQ_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    par_en_d  = bus.CFG_PAR_EN;
                    par_typ_d = bus.CFG_PAR_TYP;
                    gid_d     = win_idx;
                    if (win_upd_ptr) begin
                        ptr_d = win_idx;
                    end
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(BUSY_TO - 1)) begin
                    // Frame dropped; pointer keeps the aborted grant, timer
                    // holds at its terminal value instead of wrapping.
                    tx_err  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                // Any low cycle ends the frame, even a one-cycle dip.
                if (!bus.TX_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            gid_q     <= '0;
            timer_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            timer_q   <= timer_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    assign bus.REQ_ACK       = ack_q;
    assign bus.TX_P_DATA     = data_q;
    assign bus.TX_DATA_VALID = strobe_q;
    assign bus.TX_PAR_EN     = par_en_q;
    assign bus.TX_PAR_TYP    = par_typ_q;
    assign bus.GRANT_ID      = gid_q;
    assign bus.TX_ERR        = tx_err;
endmodule
